dmem_access_unit: RTL and testbench

- Initiator side of the data-memory interface: converts core load/store requests (valid/ready) into `memget`/`memset` strobes, address and write data for `data_memory`.
- Captures `memout` after a configurable read latency and returns results over a valid/ready response channel.
- Sits between the execute/memory stage and `data_memory`.
- Owns range checking against the 1024-word data space.

---
 rtl/dmem_access_unit_pkg.sv | 20 ++
 rtl/dmem_access_unit.sv | 110 +++++++++++
 tb/tb_dmem_access_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared widths, FSM state encoding and the data-space range check
// used by the data-memory access unit.
package dmem_access_unit_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int DMEM_ADDR_BITS = 10;
    localparam int LAT_BITS       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Any set bit above the implemented address bits falls outside the 1024-word space.
    function automatic logic in_range(input logic [WORD_SIZE-1:0] addr);
        return addr[WORD_SIZE-1:DMEM_ADDR_BITS] == '0;
    endfunction

endpackage

// File: rtl/dmem_access_unit.sv
// Initiator side of the data-memory interface: turns core load/store requests
// into memget/memset strobes and returns the result over a valid/ready channel.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [WORD_SIZE-1:0] memaddr,
    output logic [WORD_SIZE-1:0] memval,
    output logic                 memget,
    output logic                 memset,
    input  logic [WORD_SIZE-1:0] memout,
    output logic                 busy
);

    localparam logic [LAT_BITS-1:0] LAT_INIT = LAT_BITS'(READ_LAT - 1);

    state_t              state;
    state_t              state_next;
    logic                write_q;
    logic [LAT_BITS-1:0] lat_cnt;
    logic                accept;
    logic                addr_ok;

    assign addr_ok = in_range(req_addr);
    assign accept  = req_valid && (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are decoded from the registered state, so they only change at edges.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        memget     = 1'b0;
        memset     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = addr_ok ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (write_q) begin
                    memset     = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    memget = 1'b1;
                    if (lat_cnt == '0) begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address and data are captured only on acceptance and then held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q    <= 1'b0;
            lat_cnt    <= '0;
            memaddr    <= '0;
            memval     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            write_q    <= req_write;
            memaddr    <= req_addr;
            memval     <= req_wdata;
            lat_cnt    <= LAT_INIT;
            resp_rdata <= '0;
            resp_err   <= !addr_ok;
        end else if (state == ST_ACCESS && !write_q) begin
            if (lat_cnt == '0) begin
                resp_rdata <= memout;
            end else begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench: two access units (READ_LAT 1 and 3) against behavioural
// data memories, with a response scoreboard and strobe monitors.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    localparam int RL0 = 1;
    localparam int RL1 = 3;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
        int          accept;
        int          delta;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [15:0] req_addr [2];
    logic [15:0] req_wdata [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [15:0] resp_rdata [2];
    logic        resp_err [2];
    logic [15:0] memaddr [2];
    logic [15:0] memval [2];
    logic        memget [2];
    logic        memset [2];
    logic [15:0] memout [2];
    logic        busy [2];

    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];
    int          gcnt [2] = '{0, 0};

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_access_unit #(.READ_LAT(RL0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .memaddr(memaddr[0]), .memval(memval[0]), .memget(memget[0]), .memset(memset[0]),
        .memout(memout[0]), .busy(busy[0])
    );

    dmem_access_unit #(.READ_LAT(RL1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .memaddr(memaddr[1]), .memval(memval[1]), .memget(memget[1]), .memset(memset[1]),
        .memout(memout[1]), .busy(busy[1])
    );

    // Memory model: read data is only valid in the READ_LAT-th consecutive memget cycle.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end
        mem1[1023] = 16'h1234;
    end

    always @(posedge clk) begin
        if (memset[0]) mem0[memaddr[0][9:0]] <= memval[0];
        if (memset[1]) mem1[memaddr[1][9:0]] <= memval[1];
        gcnt[0] <= memget[0] ? gcnt[0] + 1 : 0;
        gcnt[1] <= memget[1] ? gcnt[1] + 1 : 0;
    end

    assign memout[0] = (memget[0] && gcnt[0] == RL0 - 1) ? mem0[memaddr[0][9:0]] : 16'hDEAD;
    assign memout[1] = (memget[1] && gcnt[1] == RL1 - 1) ? mem1[memaddr[1][9:0]] : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        total_cnt++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    // Scoreboard and strobe monitor, sampled on the falling edge.
    int   nget [2] = '{0, 0};
    int   nset [2] = '{0, 0};
    bit   seen [2] = '{0, 0};
    logic last_strobe [2] = '{1'b0, 1'b0};
    logic [15:0] last_addr [2];
    logic [15:0] last_val [2];

    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            for (int u = 0; u < 2; u++) begin
                nget[u] = 0;
                nset[u] = 0;
                seen[u] = 0;
                last_strobe[u] = 1'b0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                exp_t e;
                check("strobe_exclusive", 32'(memget[u] && memset[u]), 32'd0);
                if ((memget[u] || memset[u]) && last_strobe[u]) begin
                    check("memaddr_stable", 32'(memaddr[u]), 32'(last_addr[u]));
                    check("memval_stable", 32'(memval[u]), 32'(last_val[u]));
                end
                last_strobe[u] = memget[u] || memset[u];
                last_addr[u]   = memaddr[u];
                last_val[u]    = memval[u];
                if (memget[u]) nget[u]++;
                if (memset[u]) nset[u]++;
                if (resp_valid[u]) begin
                    if (qsize(u) == 0) begin
                        fail("resp_unexpected", "response with nothing outstanding");
                    end else begin
                        e = (u == 0) ? q0[0] : q1[0];
                        if (!seen[u]) begin
                            seen[u] = 1;
                            check("resp_latency", 32'(cyc - e.accept), 32'(e.delta));
                            check("memget_cycles", 32'(nget[u]),
                                  32'((!e.write && !e.err) ? ((u == 0) ? RL0 : RL1) : 0));
                            check("memset_cycles", 32'(nset[u]), 32'((e.write && !e.err) ? 1 : 0));
                            check("memaddr", 32'(memaddr[u]), 32'(e.addr));
                            check("memval", 32'(memval[u]), 32'(e.wdata));
                            nget[u] = 0;
                            nset[u] = 0;
                        end
                        if (resp_ready[u]) begin
                            check("resp_rdata", 32'(resp_rdata[u]), 32'(e.rdata));
                            check("resp_err", 32'(resp_err[u]), 32'(e.err));
                            if (u == 0) void'(q0.pop_front());
                            else void'(q1.pop_front());
                            seen[u] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for acceptance and records the expected response.
    task automatic apply_stimulus(input int u, input logic wr, input logic [15:0] addr,
                                  input logic [15:0] wdata, input logic [15:0] exp_rdata,
                                  input logic exp_err, output int acc);
        exp_t e;
        int   n = 0;
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        while (!req_ready[u] && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready[u]) begin
            fail("accept_timeout", "request not accepted within 50 cycles");
            req_valid[u] = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            e.write  = wr;
            e.addr   = addr;
            e.wdata  = wdata;
            e.rdata  = exp_rdata;
            e.err    = exp_err;
            e.accept = acc;
            e.delta  = exp_err ? 0 : (wr ? 1 : ((u == 0) ? RL0 : RL1));
            if (u == 0) q0.push_back(e);
            else q1.push_back(e);
            tick();
        end
    endtask

    task automatic drain(input int u);
        int n = 0;
        while (qsize(u) != 0 && n < 100) begin
            tick();
            n++;
        end
        if (qsize(u) != 0) fail("drain_timeout", "responses still outstanding after 100 cycles");
        tick();
    endtask

    task automatic check_output(input int u);
        check("rst_req_ready", 32'(req_ready[u]), 32'd1);
        check("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
        check("rst_busy", 32'(busy[u]), 32'd0);
        check("rst_memget", 32'(memget[u]), 32'd0);
        check("rst_memset", 32'(memset[u]), 32'd0);
        check("rst_resp_rdata", 32'(resp_rdata[u]), 32'd0);
        check("rst_resp_err", 32'(resp_err[u]), 32'd0);
        check("rst_memaddr", 32'(memaddr[u]), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        int acc;
        int prev;
        int n;

        vecs[0] = '{1'b1, 16'd5,     16'h00A7, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'd5,     16'h0000, 16'h00A7, 1'b0};
        vecs[2] = '{1'b1, 16'h0400,  16'hDEAD, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 16'd0,     16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 16'hFFFF,  16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 16'd1023,  16'hBEEF, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 16'd1023,  16'h0000, 16'hBEEF, 1'b0};
        vecs[7] = '{1'b1, 16'h8005,  16'h5555, 16'h0000, 1'b1};
        vecs[8] = '{1'b0, 16'd5,     16'h0000, 16'h00A7, 1'b0};

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u]  = 1'b0;
            req_write[u]  = 1'b0;
            req_addr[u]   = 16'h0;
            req_wdata[u]  = 16'h0;
            resp_ready[u] = 1'b1;
        end
        tick();
        tick();
        check_output(0);
        check_output(1);
        reset = 1'b0;
        tick();

        $display("[TB] vector table on READ_LAT=%0d unit", RL0);
        foreach (vecs[i]) begin
            apply_stimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, acc);
            req_valid[0] = 1'b0;
            drain(0);
        end

        $display("[TB] back-to-back store/load pairs");
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 1'b1, 16'(i), 16'h3C00 + 16'(i), 16'h0000, 1'b0, acc);
            if (prev >= 0) check("b2b_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
            apply_stimulus(0, 1'b0, 16'(i), 16'h0000, 16'h3C00 + 16'(i), 1'b0, acc);
            check("b2b_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
        end
        req_valid[0] = 1'b0;
        drain(0);

        $display("[TB] response backpressure");
        resp_ready[0] = 1'b0;
        apply_stimulus(0, 1'b0, 16'd5, 16'h0000, 16'h00A7, 1'b0, acc);
        req_valid[0] = 1'b0;
        n = 0;
        while (!resp_valid[0] && n < 20) begin
            tick();
            n++;
        end
        if (!resp_valid[0]) fail("bp_resp_timeout", "no resp_valid within 20 cycles");
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
            check("bp_resp_rdata", 32'(resp_rdata[0]), 32'h00A7);
            check("bp_resp_err", 32'(resp_err[0]), 32'd0);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
            if (k == 1) begin
                req_valid[0] = 1'b1;
                req_write[0] = 1'b1;
                req_addr[0]  = 16'd5;
                req_wdata[0] = 16'hFFFF;
            end
            if (k == 2) req_valid[0] = 1'b0;
            tick();
        end
        resp_ready[0] = 1'b1;
        drain(0);
        apply_stimulus(0, 1'b0, 16'd5, 16'h0000, 16'h00A7, 1'b0, acc);
        req_valid[0] = 1'b0;
        drain(0);

        $display("[TB] READ_LAT=%0d load and reset mid-load", RL1);
        apply_stimulus(1, 1'b0, 16'd1023, 16'h0000, 16'h1234, 1'b0, acc);
        req_valid[1] = 1'b0;
        drain(1);

        apply_stimulus(1, 1'b0, 16'd1023, 16'h0000, 16'h1234, 1'b0, acc);
        req_valid[1] = 1'b0;
        tick();
        check("mid_memget", 32'(memget[1]), 32'd1);
        reset = 1'b1;
        tick();
        check("post_rst_memget", 32'(memget[1]), 32'd0);
        check("post_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        check("post_rst_busy", 32'(busy[1]), 32'd0);
        check("post_rst_req_ready", 32'(req_ready[1]), 32'd1);
        reset = 1'b0;
        tick();
        apply_stimulus(1, 1'b0, 16'd1023, 16'h0000, 16'h1234, 1'b0, acc);
        req_valid[1] = 1'b0;
        drain(1);

        apply_stimulus(1, 1'b1, 16'h0400, 16'h7777, 16'h0000, 1'b1, acc);
        req_valid[1] = 1'b0;
        drain(1);
        apply_stimulus(1, 1'b0, 16'd0, 16'h0000, 16'h0000, 1'b0, acc);
        req_valid[1] = 1'b0;
        drain(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
